// File: rtl/mac_sequencer.sv
// Control FSM for one multiply-accumulate pass: clears the accumulator, then
// loads and accumulates N_TERMS operand pairs, and holds the result for the consumer.
module mac_sequencer #(
  parameter int unsigned N_TERMS = 4,
  parameter int unsigned CNT_W   = 3
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             op_load,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] term_idx
);

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StAccum,
    StDone
  } state_t;

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(N_TERMS - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge CLK) begin
    if (R) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    in_ready    = 1'b0;
    op_load     = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;

    unique case (r_state)
      StIdle: begin
        // abort wins over a simultaneous start
        if (start && !abort) w_state_nxt = StClear;
      end
      StClear: begin
        acc_clr   = 1'b1;
        busy      = 1'b1;
        w_cnt_nxt = '0;
        w_state_nxt = abort ? StIdle : StLoad;
      end
      StLoad: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (abort) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else if (in_valid) begin
          op_load     = 1'b1;
          w_state_nxt = StAccum;
        end
      end
      StAccum: begin
        busy = 1'b1;
        if (abort) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end else begin
          acc_en = 1'b1;
          // the counter saturates at the last index, so N_TERMS = 2**CNT_W never wraps
          if (r_cnt == LastIdx) begin
            w_state_nxt = StDone;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_state_nxt = StLoad;
          end
        end
      end
      StDone: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (abort || out_ready) begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = StIdle;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign term_idx = r_cnt;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: three instances (4, 1 and 8 terms) with
// hand-computed per-cycle output vectors and a strobe sanity check on every sampled cycle.
module tb_mac_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       R;
  logic [2:0] st, ab, iv, ordy;
  logic [2:0] ir, ol, ac, ae, ov, bz;
  logic [2:0] idx_a, idx_b, idx_c;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected vector layout: {in_ready, op_load, acc_clr, acc_en, out_valid, busy, term_idx}
  localparam logic [5:0] VIdle  = 6'b000000;
  localparam logic [5:0] VClr   = 6'b001001;
  localparam logic [5:0] VLoad  = 6'b110001;
  localparam logic [5:0] VStall = 6'b100001;
  localparam logic [5:0] VAcc   = 6'b000101;
  localparam logic [5:0] VDone  = 6'b000011;

  mac_sequencer #(.N_TERMS(4), .CNT_W(3)) u_a (
    .CLK(CLK), .R(R), .start(st[0]), .abort(ab[0]), .in_valid(iv[0]),
    .in_ready(ir[0]), .op_load(ol[0]), .acc_clr(ac[0]), .acc_en(ae[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .busy(bz[0]), .term_idx(idx_a)
  );

  mac_sequencer #(.N_TERMS(1), .CNT_W(3)) u_b (
    .CLK(CLK), .R(R), .start(st[1]), .abort(ab[1]), .in_valid(iv[1]),
    .in_ready(ir[1]), .op_load(ol[1]), .acc_clr(ac[1]), .acc_en(ae[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .busy(bz[1]), .term_idx(idx_b)
  );

  mac_sequencer #(.N_TERMS(8), .CNT_W(3)) u_c (
    .CLK(CLK), .R(R), .start(st[2]), .abort(ab[2]), .in_valid(iv[2]),
    .in_ready(ir[2]), .op_load(ol[2]), .acc_clr(ac[2]), .acc_en(ae[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .busy(bz[2]), .term_idx(idx_c)
  );

  function automatic logic [8:0] obs(input int s);
    logic [2:0] i;
    i = (s == 0) ? idx_a : (s == 1) ? idx_b : idx_c;
    return {ir[s], ol[s], ac[s], ae[s], ov[s], bz[s], i};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input int s, input logic i_st, input logic i_ab, input logic i_iv,
                       input logic i_or);
    st[s]   = i_st;
    ab[s]   = i_ab;
    iv[s]   = i_iv;
    ordy[s] = i_or;
    #1;
  endtask

  task automatic strobes();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      assert (((2'(ol[d]) + 2'(ac[d]) + 2'(ae[d])) <= 2'd1) && (!ol[d] || ir[d])) else begin
        n_bad++;
        $error("FAIL strobe dut%0d ol=%b ac=%b ae=%b ir=%b required exclusive and ol->ir",
               d, ol[d], ac[d], ae[d], ir[d]);
      end
    end
  endtask

  task automatic chk(input string tag, input int s, input logic [5:0] v, input logic [2:0] i,
                     input bit care_idx);
    logic [8:0] o, e, m;
    o = obs(s);
    e = {v, i};
    m = care_idx ? 9'h1FF : 9'h1F8;
    n_cmp++;
    assert ((o & m) === (e & m)) else begin
      n_bad++;
      $error("FAIL %s dut%0d observed=%b expected=%b mask=%b", tag, s, o, e, m);
    end
    strobes();
  endtask

  // Full pass from IDLE with in_valid and out_ready held high.
  task automatic pass(input string tag, input int s, input int n);
    drive(s, 1'b1, 1'b0, 1'b1, 1'b1);
    chk({tag, "_idle"}, s, VIdle, 3'd0, 1'b0);
    tick();
    drive(s, 1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, "_clr"}, s, VClr, 3'd0, 1'b0);
    for (int t = 0; t < n; t++) begin
      tick();
      chk({tag, "_load"}, s, VLoad, 3'(t), 1'b1);
      tick();
      chk({tag, "_acc"}, s, VAcc, 3'(t), 1'b1);
    end
    tick();
    chk({tag, "_done"}, s, VDone, 3'(n - 1), 1'b1);
    tick();
    chk({tag, "_end"}, s, VIdle, 3'd0, 1'b0);
    drive(s, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    R = 1'b1;
    st = '0; ab = '0; iv = '0; ordy = '0;
    tick();
    tick();
    R = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) chk("reset", d, VIdle, 3'd0, 1'b1);

    pass("b2b", 0, 4);

    // Reset during the second ACCUM cycle
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("rst_clr", 0, VClr, 3'd0, 1'b1);
    tick(); tick(); tick(); tick();
    chk("rst_acc1", 0, VAcc, 3'd1, 1'b1);
    R = 1'b1;
    tick();
    R = 1'b0;
    #1;
    chk("rst_mid", 0, VIdle, 3'd0, 1'b1);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    pass("after_rst", 0, 4);

    // Stalled operands at term 2, then consumer backpressure in DONE
    drive(0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int t = 0; t < 2; t++) begin
      tick(); chk("stl_load", 0, VLoad, 3'(t), 1'b1);
      tick(); chk("stl_acc", 0, VAcc, 3'(t), 1'b1);
    end
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall0", 0, VStall, 3'd2, 1'b1);
    tick(); chk("stall1", 0, VStall, 3'd2, 1'b1);
    tick(); chk("stall2", 0, VStall, 3'd2, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("resume_load", 0, VLoad, 3'd2, 1'b1);
    tick(); chk("resume_acc", 0, VAcc, 3'd2, 1'b1);
    tick(); chk("resume_load3", 0, VLoad, 3'd3, 1'b1);
    tick(); chk("resume_acc3", 0, VAcc, 3'd3, 1'b1);
    for (int c = 0; c < 5; c++) begin
      tick();
      drive(0, (c == 2), 1'b0, 1'b1, 1'b0);
      chk("bp_hold", 0, VDone, 3'd3, 1'b1);
    end
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("bp_release", 0, VDone, 3'd3, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bp_idle", 0, VIdle, 3'd0, 1'b0);

    // Abort in LOAD at term 1: op_load suppressed, then IDLE with cnt cleared
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(); tick(); tick();
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_load", 0, VStall, 3'd1, 1'b1);
    tick();
    drive(0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("abort_idle", 0, VIdle, 3'd0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("abort_vs_start", 0, VIdle, 3'd0, 1'b1);

    // Abort in ACCUM suppresses acc_en
    drive(0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    chk("abacc_load", 0, VLoad, 3'd0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_acc", 0, 6'b000001, 3'd0, 1'b1);
    tick();
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_acc_idle", 0, VIdle, 3'd0, 1'b1);

    pass("n1", 1, 1);
    pass("n8", 2, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout compared=%0d required=finish", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Moore/Mealy FSM that drives one multiply-accumulate pass in the MAC unit.
- Generates the load and clear controls for the single-bit register slices that make up the operand and accumulator banks.
- Accepts N_TERMS operand pairs through a valid/ready handshake, accumulates one product per pair, then holds a result-valid until the consumer takes it.
- Sits between the operand source and the MAC datapath; it contains no arithmetic of its own.

Parameters:
- N_TERMS, 4, number of operand pairs per accumulation; legal range 1..2^CNT_W.
- CNT_W, 3, width of the term counter and the term_idx output.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- R  input  1  synchronous active-high reset.
- start  input  1  request a new accumulation; sampled only in IDLE.
- abort  input  1  synchronous abandon of the current pass.
- in_valid  input  1  operand pair present on the datapath inputs.
- in_ready  output  1  sequencer will accept an operand pair this cycle.
- op_load  output  1  load strobe (S) for the operand register banks.
- acc_clr  output  1  clear strobe (R) for the accumulator register bank.
- acc_en  output  1  accumulator load strobe (S); captures accumulator + product.
- out_valid  output  1  accumulator holds the final result.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in every state except IDLE.
- term_idx  output  CNT_W  index of the operand pair currently being handled.

Behaviour:
- Reset: the states are IDLE, CLEAR, LOAD, ACCUM and DONE. R=1 at a clock edge forces state=IDLE and cnt=0. It also forces in_ready, op_load, acc_clr, acc_en, out_valid, busy and term_idx to 0 from the next cycle on. R overrides every other input, in any state.
- Priority: R > abort > normal transitions.
- IDLE: all outputs are 0. If start=1 -> CLEAR; otherwise stay in IDLE.
- CLEAR: lasts exactly one cycle. acc_clr=1 and busy=1. cnt is set to 0. Next state is LOAD.
- LOAD:
  - in_ready=1.
  - op_load = in_valid (combinational, Mealy).
  - If in_valid=1 -> ACCUM; else stay in LOAD with in_ready held high. There is no timeout.
- ACCUM: lasts exactly one cycle. acc_en=1. The operands loaded on the previous edge feed the product.
  - If cnt==N_TERMS-1 -> DONE.
  - Otherwise cnt<=cnt+1 -> LOAD.
- DONE: out_valid=1 and busy=1.
  - If out_ready=1 -> IDLE.
  - out_valid stays high until the handshake completes.
  - start is ignored in DONE.
- abort=1 in CLEAR, LOAD, ACCUM or DONE -> IDLE on the next edge; cnt<=0.
  - acc_en is suppressed in the abort cycle.
  - op_load is suppressed in the abort cycle.
  - The accumulator contents are left undefined; the next pass clears them.
  - abort in IDLE has no effect; abort takes priority over a simultaneous start.
- term_idx = cnt in all states. It is not a valid index in IDLE or DONE.
- Strobes: op_load, acc_clr and acc_en are mutually exclusive; no two are ever high in the same cycle. op_load is never high unless in_ready=1.
- Latency: start accepted -> in_ready high 2 cycles later. With in_valid held high, one pass takes 2 + 2·N_TERMS cycles from start to out_valid.
- Wrap: when N_TERMS=2^CNT_W, cnt stops at N_TERMS-1 and never overflows.

Test Plan:
- Reset mid-pass: run N_TERMS=4 with in_valid held high and assert R during the 2nd ACCUM cycle. Next cycle: all outputs 0, busy=0. A following start runs a full 4-term pass.
- Back-to-back pass: start=1 for 1 cycle with in_valid=1 and out_ready=1 continuously. Observe acc_clr at cycle 1, then op_load/acc_en alternating 4 times (term_idx 0,1,2,3). out_valid=1 at cycle 10 for exactly 1 cycle, then busy=0.
- Stalled operands: deassert in_valid for 3 cycles while in LOAD at term_idx=2. Required: in_ready stays 1, op_load=0, acc_en=0 and term_idx stays 2 throughout. The pass resumes when in_valid returns.
- Consumer backpressure: hold out_ready=0 for 5 cycles in DONE and pulse start during that time. Required: out_valid held, state unchanged, start ignored. out_ready=1 -> IDLE on the next edge.
- Abort vs start: assert abort in LOAD at term_idx=1 -> IDLE next cycle, term_idx=0, no acc_en. Then raise start and abort together in IDLE -> the FSM stays in IDLE.
- Strobe check on every cycle of all runs: op_load+acc_clr+acc_en <= 1, and op_load implies in_ready. Repeat with N_TERMS=1 and with N_TERMS=8, CNT_W=3 to cover the wrap boundary.
